r_num_scan: RTL and testbench
=============================

Name: r_num_scan

Overview:
- Read-side companion to the enabled 3-bit number registers in the health-monitor datapath.
- Takes a flattened bus of NUM_DIGITS stored 3-bit codes and captures a coherent snapshot on request, applied only at a frame boundary so the display never tears mid-scan.
- Time-multiplexes the snapshot onto a common-anode seven-segment display: one digit per refresh slot, with per-digit blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2. Divider width is $clog2(REFRESH_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- load  in  1  snapshot request; single-cycle pulse or level
- vals  in  3*NUM_DIGITS  stored codes; digit i is vals[3*i+2:3*i]
- blank  in  NUM_DIGITS  per-digit blank mask; 1 = digit dark; sampled live, not snapshotted
- an  out  NUM_DIGITS  digit enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- load_ack  out  1  one-cycle pulse when a snapshot is applied

Behaviour:
- Reset (async assert, sync release):
  - an = all ones; seg = 7'h7F; load_ack = 0.
  - snap[*] = 0; idx = 0; div = 0; pending = 0.
- Divider: div counts 0..REFRESH_DIV-1 and wraps to 0. tick = (div == REFRESH_DIV-1).
- Digit index: on tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0. frame_end = tick && (idx == NUM_DIGITS-1).
- Snapshot handshake:
  - pend_n = pending | load.
  - If pend_n && frame_end: snap[*] <= vals as sampled that cycle; pending <= 0; load_ack <= 1 next cycle.
  - Otherwise: pending <= pend_n; load_ack <= 0.
  - Multiple loads before the frame end merge into one capture and one ack.
  - A load asserted on the frame_end cycle is captured in that same cycle.
  - Worst-case latency from load to ack is NUM_DIGITS*REFRESH_DIV cycles.
- Outputs are registered and computed from the current idx, snap and blank, so they lag an idx change by 1 cycle.
  - an = ~(1 << idx), or all ones if blank[idx].
  - seg = DEC(snap[idx]), or 7'h7F if blank[idx].
- DEC, 3-bit to active-low segment codes:
  - 0 -> 40, 1 -> 79, 2 -> 24, 3 -> 30
  - 4 -> 19, 5 -> 12, 6 -> 02, 7 -> 78 (hex)
- A newly captured snapshot first appears on digit 0 one cycle after the capturing frame_end.
- NUM_DIGITS = 1: every tick is a frame_end.
- Reset mid-scan or mid-pending: everything returns immediately to reset values; a pending request is dropped and no ack is produced.
- vals changing while no capture is in progress has no effect on the outputs.

Decomposition:
- Package r_num_pkg holds:
  - seg7 code constants SEG_0..SEG_7 and SEG_OFF = 7'h7F;
  - function seg7_dec3(logic [2:0]) returning logic [6:0].
- Sub-module r_num_tick (parameter REFRESH_DIV; ports clk, rst, tick): free-running divider; reused by other display blocks.
- Snapshot, index and output registers stay in r_num_scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset with vals = 12'hFFF: an = 4'hF, seg = 7'h7F. First frame shows four zeros (seg = 40 in each slot), an walks E, D, B, 7.
- Single load at cycle 2 with vals = {3'd3, 3'd2, 3'd1, 3'd0}: capture at the first frame_end (cycle 15) and load_ack pulses once at cycle 16. Digits then show 40, 79, 24, 30 in slots 0..3.
- Three load pulses within one frame, vals changing between them: exactly one load_ack; the captured value equals vals on the frame_end cycle.
- load asserted exactly on the frame_end cycle: captured that cycle, ack the next cycle, no extra frame of delay.
- blank = 4'b0100 during scan: slot 2 gives an = F and seg = 7F; other slots are unaffected; toggling blank mid-slot takes effect 1 cycle later.
- Async rst pulse mid-frame with pending = 1: outputs return to reset values without waiting for a clk edge; no load_ack afterwards; snap reads 0.

Source files
------------

// File: rtl/r_num_pkg.sv
// Shared constants and the 3-bit to seven-segment decoder for the number display blocks.
package r_num_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_dec3(input logic [2:0] code);
    logic [6:0] seg;
    unique case (code)
      3'd0: seg = SEG_0;
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      3'd7: seg = SEG_7;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/r_num_tick.sv
// Free-running refresh divider; tick is high for one cycle every REFRESH_DIV cycles.
module r_num_tick #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(REFRESH_DIV - 1);

  logic [DivW-1:0] r_div;
  logic            w_tick;

  assign w_tick = (r_div == DivMax);
  assign tick   = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/r_num_scan.sv
// Snapshots stored 3-bit codes at frame boundaries and scans them onto a
// common-anode seven-segment display with per-digit blanking.
module r_num_scan
  import r_num_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [3*NUM_DIGITS-1:0] vals,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    load_ack
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_pend_n;
  logic [NUM_DIGITS-1:0] w_an_sel;

  logic [IdxW-1:0]       r_idx;
  logic                  r_pending;
  logic                  r_load_ack;
  logic [2:0]            r_snap [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  r_num_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_frame_end = w_tick && (r_idx == IdxMax);
  assign w_pend_n    = r_pending | load;

  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_frame_end) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Captures only on frame_end so a whole frame always shows one coherent snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= '0;
    end else if (w_pend_n && w_frame_end) begin
      r_pending  <= 1'b0;
      r_load_ack <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= vals[3*i +: 3];
    end else begin
      r_pending  <= w_pend_n;
      r_load_ack <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else if (blank[r_idx]) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= seg7_dec3(r_snap[r_idx]);
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign load_ack = r_load_ack;

endmodule

// File: tb/tb_r_num_scan.sv
// Directed bench for r_num_scan with NUM_DIGITS=4, REFRESH_DIV=4 (frame = 16 cycles).
module tb_r_num_scan;

  localparam int unsigned NumDigits  = 4;
  localparam int unsigned RefreshDiv = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] vals;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        load_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;

  r_num_scan #(
    .NUM_DIGITS (NumDigits),
    .REFRESH_DIV(RefreshDiv)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .vals    (vals),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Cycle k is the clock period in which the divider holds k%4 and idx holds (k/4)%4.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (load_ack) ack_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    check_val({tag, "_an"}, 32'(an), 32'(exp_an));
    check_val({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    vals  = 12'hFFF;
    blank = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_disp("reset", 4'hF, 7'h7F);
    check_val("reset_ack", 32'(load_ack), 32'd0);
    rst = 1'b0;
    cyc = 0;
    check_disp("cyc0", 4'hF, 7'h7F);

    // First frame shows zeros; single load at cycle 2.
    run_to(1);  check_disp("f0_d0", 4'hE, 7'h40);
    run_to(2);  load = 1'b1; vals = 12'h688;
    run_to(3);  load = 1'b0;
    run_to(5);  check_disp("f0_d1", 4'hD, 7'h40);
    run_to(9);  check_disp("f0_d2", 4'hB, 7'h40);
    run_to(13); check_disp("f0_d3", 4'h7, 7'h40);
    run_to(15); check_val("ack_pre", 32'(load_ack), 32'd0);
    run_to(16); check_val("ack_single", 32'(load_ack), 32'd1);
    run_to(17); check_val("ack_post", 32'(load_ack), 32'd0);
    check_disp("f1_d0", 4'hE, 7'h40);
    ack_cnt = 0;

    // Three merged loads; capture must take vals from the frame_end cycle (31).
    run_to(18); load = 1'b1; vals = 12'h111;
    run_to(19); load = 1'b0;
    run_to(21); check_disp("f1_d1", 4'hD, 7'h79);
    run_to(22); load = 1'b1; vals = 12'h222;
    run_to(23); load = 1'b0;
    run_to(25); check_disp("f1_d2", 4'hB, 7'h24);
    run_to(26); load = 1'b1; vals = 12'h333;
    run_to(27); load = 1'b0;
    run_to(29); check_disp("f1_d3", 4'h7, 7'h30);
    run_to(30); vals = 12'hABC;
    run_to(31); vals = 12'hFAC;
    run_to(32); check_val("ack_merged", 32'(load_ack), 32'd1);
    run_to(33); check_disp("f2_d0", 4'hE, 7'h19);
    run_to(37); check_disp("f2_d1", 4'hD, 7'h12);
    run_to(40); check_val("ack_count", 32'(ack_cnt), 32'd1);
    run_to(41); check_disp("f2_d2", 4'hB, 7'h02);
    run_to(45); check_disp("f2_d3", 4'h7, 7'h78);

    // Load only on the frame_end cycle.
    run_to(47); load = 1'b1; vals = 12'h1C7;
    run_to(48); load = 1'b0;
    check_val("ack_fe", 32'(load_ack), 32'd1);
    run_to(49); check_disp("f3_d0", 4'hE, 7'h78);
    run_to(50); vals = 12'h000;
    run_to(53); check_disp("f3_d1", 4'hD, 7'h40);
    run_to(57); check_disp("f3_d2", 4'hB, 7'h78);

    // Blank digit 2, then release it mid-slot.
    run_to(60); blank = 4'b0100;
    run_to(61); check_disp("blk_d3", 4'h7, 7'h40);
    run_to(69); check_disp("blk_d1", 4'hD, 7'h40);
    run_to(73); check_disp("blk_d2", 4'hF, 7'h7F);
    run_to(74); check_disp("blk_hold", 4'hF, 7'h7F);
    blank = 4'b0000;
    run_to(75); check_disp("blk_rel", 4'hB, 7'h78);
    run_to(77); check_disp("blk_d3b", 4'h7, 7'h40);

    // Async reset with a request pending.
    run_to(82); load = 1'b1; vals = 12'hFFF;
    run_to(83); load = 1'b0;
    run_to(85);
    #2;
    rst = 1'b1;
    #1;
    check_disp("arst", 4'hF, 7'h7F);
    check_val("arst_ack", 32'(load_ack), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cyc     = 0;
    ack_cnt = 0;
    run_to(1);  check_disp("rr_d0", 4'hE, 7'h40);
    run_to(9);  check_disp("rr_d2", 4'hB, 7'h40);
    run_to(17); check_disp("rr_f1d0", 4'hE, 7'h40);
    run_to(24); check_val("rr_no_ack", 32'(ack_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
